// File: rtl/cordic_rot_sched_if.sv
// ---------------------------------------------------------------------------
// cordic_rot_sched_if
//
// Bundles every request, response and engine signal of cordic_rot_sched.
//   req0_* / req1_* : request channels (valid/ready, x, y, angle)
//   rsp0_* / rsp1_* : response channels (valid/ready, x, y, err)
//   core_*          : CORDIC rotation engine (start pulse, operands, results)
//
// Modports:
//   slave  : the scheduler (cordic_rot_sched) side
//   master : the environment side (requesters, response sinks, engine)
//
// Handshake semantics (all req/rsp channels): a transfer happens on a rising
// clock edge where valid and ready are both 1. Once valid is raised, the
// source holds valid and payload stable until that transfer edge; ready may
// depend combinationally on valid.
//
// Parameters: N = data MSB index (signed Q12.20), M = angle MSB index.
// ---------------------------------------------------------------------------
interface cordic_rot_sched_if #(
  parameter int N = 31,
  parameter int M = 31
);
  logic              req0_valid;
  logic              req0_ready;
  logic signed [N:0] req0_x;
  logic signed [N:0] req0_y;
  logic [M:0]        req0_angle;

  logic              req1_valid;
  logic              req1_ready;
  logic signed [N:0] req1_x;
  logic signed [N:0] req1_y;
  logic [M:0]        req1_angle;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic signed [N:0] rsp0_x;
  logic signed [N:0] rsp0_y;
  logic              rsp0_err;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic signed [N:0] rsp1_x;
  logic signed [N:0] rsp1_y;
  logic              rsp1_err;

  logic              core_start;
  logic signed [N:0] core_x0;
  logic signed [N:0] core_y0;
  logic [M:0]        core_angle;
  logic signed [N:0] core_xf;
  logic signed [N:0] core_yf;
  logic              core_done;

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_angle,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_angle,
    output req1_ready,
    output rsp0_valid, rsp0_x, rsp0_y, rsp0_err,
    input  rsp0_ready,
    output rsp1_valid, rsp1_x, rsp1_y, rsp1_err,
    input  rsp1_ready,
    output core_start, core_x0, core_y0, core_angle,
    input  core_xf, core_yf, core_done
  );

  modport master (
    output req0_valid, req0_x, req0_y, req0_angle,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_angle,
    input  req1_ready,
    input  rsp0_valid, rsp0_x, rsp0_y, rsp0_err,
    output rsp0_ready,
    input  rsp1_valid, rsp1_x, rsp1_y, rsp1_err,
    output rsp1_ready,
    input  core_start, core_x0, core_y0, core_angle,
    output core_xf, core_yf, core_done
  );
endinterface

// File: rtl/cordic_rot_sched.sv
// ---------------------------------------------------------------------------
// cordic_rot_sched
//
// Two-requester scheduler in front of a single CORDIC rotation engine.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Contention between the two requesters is resolved round-robin.
//
// Ports:
//   clk       : clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   bus       : cordic_rot_sched_if.slave (request, response, engine signals)
//   busy      : high in every state except IDLE
//   state_dbg : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Parameters: N (data MSB), M (angle MSB), TIMEOUT (max WAIT cycles).
//
// Optional feature: define CORDIC_ROT_SCHED_TIMEOUT_EN to add a WAIT-state
// watchdog that returns an error response (err=1, x=y=0) when core_done does
// not arrive within TIMEOUT WAIT cycles. Without it WAIT only exits on
// core_done and rsp*_err is tied to 0.
// ---------------------------------------------------------------------------
module cordic_rot_sched #(
  parameter int N       = 31,
  parameter int M       = 31,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  cordic_rot_sched_if.slave  bus,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // 360 degrees in unsigned Q12.20
  localparam logic [M:0] ANG360 = (M+1)'(64'h1680_0000);

  state_t            state;
  state_t            state_nx;
  logic              start;

  logic              rr;        // requester that wins when both are valid
  logic              gnt_q;     // requester owning the transaction in flight
  logic signed [N:0] x_q;
  logic signed [N:0] y_q;
  logic [M:0]        ang_q;
  logic signed [N:0] rx_q;
  logic signed [N:0] ry_q;
  logic              err;

  logic              req_fire;
  logic              req_sel;
  logic signed [N:0] sel_x;
  logic signed [N:0] sel_y;
  logic [M:0]        sel_ang;
  logic              rsp_fire;
  logic              tmo_hit;

  // Ready is granted combinationally: a lone valid wins, otherwise rr picks.
  assign bus.req0_ready = (state == IDLE) && !rst && bus.req0_valid &&
                          (!bus.req1_valid || !rr);
  assign bus.req1_ready = (state == IDLE) && !rst && bus.req1_valid &&
                          (!bus.req0_valid || rr);

  assign req_fire = (bus.req0_valid && bus.req0_ready) ||
                    (bus.req1_valid && bus.req1_ready);
  // At most one ready is high, so req1_ready alone identifies the winner.
  assign req_sel  = bus.req1_ready;
  assign sel_x    = req_sel ? bus.req1_x     : bus.req0_x;
  assign sel_y    = req_sel ? bus.req1_y     : bus.req0_y;
  assign sel_ang  = req_sel ? bus.req1_angle : bus.req0_angle;

  assign rsp_fire = (state == RESP) && (gnt_q ? bus.rsp1_ready : bus.rsp0_ready);

`ifdef CORDIC_ROT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // tmo_cnt counts completed WAIT cycles without done; a done in the last
  // counted cycle still wins because done is tested first.
  assign tmo_hit = (state == WAIT) && !bus.core_done &&
                   (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == WAIT && !bus.core_done) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state == WAIT) begin
        if (bus.core_done) begin
          err_q <= 1'b0;
        end else if (tmo_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state and core_start
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      IDLE:  if (req_fire) state_nx = ISSUE;
      ISSUE: begin
        start    = 1'b1;
        state_nx = WAIT;
      end
      WAIT:  if (bus.core_done || tmo_hit) state_nx = RESP;
      RESP:  if (rsp_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, result capture, round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr    <= 1'b0;
      gnt_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      ang_q <= '0;
      rx_q  <= '0;
      ry_q  <= '0;
    end else begin
      if (state == IDLE && req_fire) begin
        gnt_q <= req_sel;
        x_q   <= sel_x;
        y_q   <= sel_y;
        // Single wrap: angles of 720 deg and above are not reduced further.
        ang_q <= (sel_ang >= ANG360) ? (sel_ang - ANG360) : sel_ang;
      end
      if (state == WAIT) begin
        if (bus.core_done) begin
          rx_q <= bus.core_xf;
          ry_q <= bus.core_yf;
        end else if (tmo_hit) begin
          rx_q <= '0;
          ry_q <= '0;
        end
      end
      if (rsp_fire) begin
        rr <= ~gnt_q;
      end
    end
  end

  assign bus.core_start = start;
  assign bus.core_x0    = x_q;
  assign bus.core_y0    = y_q;
  assign bus.core_angle = ang_q;

  assign bus.rsp0_valid = (state == RESP) && !gnt_q;
  assign bus.rsp1_valid = (state == RESP) &&  gnt_q;
  assign bus.rsp0_x     = rx_q;
  assign bus.rsp0_y     = ry_q;
  assign bus.rsp1_x     = rx_q;
  assign bus.rsp1_y     = ry_q;
  assign bus.rsp0_err   = err;
  assign bus.rsp1_err   = err;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
